// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, status bit indices, FSM encoding and timeout default
package spi_pkg;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 255;

  // Bit positions inside the 4-bit SPI status/command word; bit 3 is reserved.
  localparam int ST_AINC = 0;
  localparam int ST_RD   = 1;
  localparam int ST_WR   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

endpackage

// File: rtl/spi_bus_bridge_if.sv
// rtl/spi_bus_bridge_if.sv - request/ack bus between the bridge and the system bus
// Ports (signals):
//   bus_req   access request, held until ack or timeout
//   bus_we    1 = write, 0 = read; valid while bus_req is high
//   bus_addr  access address
//   bus_wdata write data
//   bus_rdata read data, valid with bus_ack
//   bus_ack   one-cycle completion pulse
// Modports: master = bridge side, slave = bus target side.
interface spi_bus_bridge_if #(
  parameter int ADDR_W = spi_pkg::ADDR_W,
  parameter int DATA_W = spi_pkg::DATA_W
);

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/spi_bus_timer.sv
// rtl/spi_bus_timer.sv - counts cycles of an outstanding bus access and flags expiry
// Ports:
//   clk, reset_n  clock and async active-low reset
//   start         access launched; counting begins from zero
//   clear         access finished (ack or expiry); counter stops and returns to zero
//   expired       high in the TIMEOUT-th cycle of an access with no ack
module spi_bus_timer #(
  parameter int TIMEOUT = spi_pkg::TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic clear,
  output logic expired
);
  import spi_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;
  logic          running;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      running <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      count   <= count + 1'b1;
    end
  end

  // count is 0 in the first busy cycle, so TIMEOUT-1 marks the last allowed one.
  assign expired = running && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/spi_bus_bridge.sv
// rtl/spi_bus_bridge.sv - turns SPI address/status/data pulses into single bus accesses
// Ports:
//   clk, reset_n   clock and async active-low reset
//   address_ready  pulse: addr valid; loads addr_q and clears both error flags
//   status_ready   pulse: status valid; a read command launches a read
//   data_ready     pulse: wdata valid; launches a write or a burst-read prefetch
//   cs_n_o         SPI chip select; while high no new access launches
//   addr, status, wdata  SPI-side captured fields
//   rdata          last read word (all-ones after a read timeout)
//   busy           FSM not idle
//   bus_err        sticky timeout flag
//   ovr_err        sticky flag: a pulse arrived while busy and was dropped
//   bus            request/ack bus (master side)
module spi_bus_bridge #(
  parameter int ADDR_W  = spi_pkg::ADDR_W,
  parameter int DATA_W  = spi_pkg::DATA_W,
  parameter int TIMEOUT = spi_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              address_ready,
  input  logic              status_ready,
  input  logic              data_ready,
  input  logic              cs_n_o,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        status,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              bus_err,
  output logic              ovr_err,
  spi_bus_bridge_if.master  bus
);
  import spi_pkg::*;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        status_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic              bus_we_q;
  logic              launch_rd, launch_wr, ack_done, to_done;
  logic              timer_start, timer_clear, expired;
  logic              overrun;
  logic              status_unused;

  // Reserved command bit is stored but has no function.
  assign status_unused = status_q[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    launch_rd = 1'b0;
    launch_wr = 1'b0;
    ack_done  = 1'b0;
    to_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cs_n_o) begin
          // A read command uses the incoming status; data_ready decisions use
          // the command already latched in status_q.
          if (status_ready && status[ST_RD] && !status[ST_WR])
            launch_rd = 1'b1;
          else if (data_ready && status_q[ST_WR])
            launch_wr = 1'b1;
          else if (data_ready && status_q[ST_RD] && status_q[ST_AINC])
            launch_rd = 1'b1;
        end
        if (launch_rd)      state_nx = S_RD;
        else if (launch_wr) state_nx = S_WR;
      end
      S_RD, S_WR: begin
        if (bus.bus_ack) begin
          ack_done = 1'b1;
          state_nx = S_IDLE;
        end else if (expired) begin
          to_done  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign overrun     = busy && (status_ready || data_ready);
  assign timer_start = launch_rd || launch_wr;
  assign timer_clear = ack_done || to_done;

  spi_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (timer_start),
    .clear   (timer_clear),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      status_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
      rdata       <= '0;
      bus_err     <= 1'b0;
      ovr_err     <= 1'b0;
    end else begin
      // A fresh address wins over an auto-increment landing in the same cycle.
      if (address_ready) begin
        addr_q  <= addr;
        bus_err <= 1'b0;
        ovr_err <= 1'b0;
      end else if (ack_done && status_q[ST_AINC]) begin
        addr_q  <= addr_q + 1'b1;
      end
      // The command is frozen while an access is outstanding so the in-flight
      // auto-increment decision cannot be altered by a dropped pulse.
      if (status_ready && !busy) status_q <= status;
      if (launch_rd || launch_wr) begin
        bus_addr_q <= addr_q;
        bus_we_q   <= launch_wr;
      end
      if (launch_wr) bus_wdata_q <= wdata;
      if (state == S_RD) begin
        if (ack_done)     rdata <= bus.bus_rdata;
        else if (to_done) rdata <= '1;
      end
      if (to_done) bus_err <= 1'b1;
      if (overrun) ovr_err <= 1'b1;
    end
  end

  assign bus.bus_req   = busy;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// tb/tb_spi_bus_bridge.sv - bench for spi_bus_bridge
module tb_spi_bus_bridge;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          address_ready = 1'b0;
  logic          status_ready = 1'b0;
  logic          data_ready = 1'b0;
  logic          cs_n_o = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0]    status = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          busy, bus_err, ovr_err;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] m_addr;
  logic [3:0]    m_status;
  logic [DW-1:0] m_rdata;
  logic          m_berr, m_oerr;

  logic [3:0] sts [6] = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111};

  always #5 clk = ~clk;

  spi_bus_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  spi_bus_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address_ready (address_ready),
    .status_ready  (status_ready),
    .data_ready    (data_ready),
    .cs_n_o        (cs_n_o),
    .addr          (addr),
    .status        (status),
    .wdata         (wdata),
    .rdata         (rdata),
    .busy          (busy),
    .bus_err       (bus_err),
    .ovr_err       (ovr_err),
    .bus           (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input logic [AW-1:0] a);
    addr = a; address_ready = 1'b1;
    @(negedge clk);
    address_ready = 1'b0;
    m_addr = a; m_berr = 1'b0; m_oerr = 1'b0;
  endtask

  task automatic set_status(input logic [3:0] s);
    status = s; status_ready = 1'b1;
    @(negedge clk);
    status_ready = 1'b0;
    m_status = s;
  endtask

  task automatic send_data(input logic [DW-1:0] w);
    wdata = w; data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  // Called one cycle after the trigger pulse: the request must already be up.
  task automatic serve(input string tag, input logic exp_we, input logic [AW-1:0] exp_addr,
                       input logic [DW-1:0] exp_wd, input int wait_n, input logic [DW-1:0] rv);
    int held;
    chk({tag, ".req"},  bus.bus_req, 1);
    chk({tag, ".we"},   bus.bus_we, exp_we);
    chk({tag, ".addr"}, bus.bus_addr, exp_addr);
    if (exp_we) chk({tag, ".wdata"}, bus.bus_wdata, exp_wd);
    held = 1;
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      if (bus.bus_req !== 1'b1) held = 0;
    end
    if (wait_n > 0) chk({tag, ".held"}, held, 1);
    bus.bus_rdata = rv; bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0; bus.bus_rdata = DW'($urandom);
    if (!exp_we) m_rdata = rv;
    if (m_status[0]) m_addr = m_addr + 1'b1;
    chk({tag, ".busy"},  busy, 0);
    chk({tag, ".rdata"}, rdata, m_rdata);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [3:0]    st;
    logic [DW-1:0] w;
    int            n;

    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    m_addr = '0; m_status = '0; m_rdata = '0; m_berr = 1'b0; m_oerr = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst.req", bus.bus_req, 0);
    chk("rst.we", bus.bus_we, 0);
    chk("rst.addr", bus.bus_addr, 0);
    chk("rst.wdata", bus.bus_wdata, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.busy", busy, 0);
    chk("rst.errs", {bus_err, ovr_err}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // addr_q resets to zero: first read goes to address 0
    set_status(4'b0010);
    serve("rst_rd", 0, 20'h00000, 0, 0, 16'h0C0C);

    // Single read
    set_addr(20'h00010);
    set_status(4'b0010);
    serve("rd", 0, 20'h00010, 0, 3, 16'hBEEF);
    chk("rd.rdata_k", rdata, 16'hBEEF);
    set_status(4'b0010);
    serve("rd_again", 0, 20'h00010, 0, 1, 16'h1111);

    // Write burst with address wrap
    set_addr(20'hFFFFF);
    set_status(4'b0101);
    chk("wb.noreq", bus.bus_req, 0);
    send_data(16'h1234);
    serve("wb0", 1, 20'hFFFFF, 16'h1234, 2, 16'hDEAD);
    send_data(16'h5678);
    serve("wb1", 1, 20'h00000, 16'h5678, 0, 16'hDEAD);

    // Read burst with prefetch
    set_addr(20'h00100);
    set_status(4'b0011);
    serve("rb0", 0, 20'h00100, 0, 1, 16'hA001);
    send_data(16'h0000);
    serve("rb1", 0, 20'h00101, 0, 2, 16'hA002);
    send_data(16'h0000);
    serve("rb2", 0, 20'h00102, 0, 0, 16'hA003);
    chk("rb.rdata_k", rdata, 16'hA003);

    // Timeout
    set_addr(20'h00200);
    set_status(4'b0010);
    n = 0;
    while (bus.bus_req === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("to.cycles", n, TO);
    chk("to.rdata", rdata, 16'hFFFF);
    chk("to.berr", bus_err, 1);
    chk("to.busy", busy, 0);
    m_rdata = 16'hFFFF;
    set_addr(20'h00200);
    chk("to.berr_clr", bus_err, 0);
    set_status(4'b0010);
    serve("to_noinc", 0, 20'h00200, 0, 0, 16'h2222);

    // Write-only command launches no read; null command launches nothing
    set_status(4'b0110);
    chk("wo.noreq", bus.bus_req, 0);
    chk("wo.rdata", rdata, m_rdata);
    set_status(4'b0000);
    send_data(16'h3333);
    chk("null.noreq", bus.bus_req, 0);
    @(negedge clk);
    chk("null.busy", busy, 0);

    // Stray ack while idle
    bus.bus_rdata = 16'h5A5A; bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    chk("idle_ack.rdata", rdata, m_rdata);
    chk("idle_ack.busy", busy, 0);

    // Chip select high blocks launch but not completion
    cs_n_o = 1'b1;
    set_status(4'b0010);
    chk("cs.noreq", bus.bus_req, 0);
    cs_n_o = 1'b0;
    set_status(4'b0010);
    cs_n_o = 1'b1;
    serve("cs_inflight", 0, m_addr, 0, 2, 16'h4444);
    cs_n_o = 1'b0;

    // Overrun during a read
    set_status(4'b0010);
    send_data(16'h7777);
    m_oerr = 1'b1;
    chk("ovr.flag", ovr_err, m_oerr);
    serve("ovr_rd", 0, m_addr, 0, 0, 16'h5555);
    @(negedge clk);
    chk("ovr.nowr", bus.bus_req, 0);
    chk("ovr.sticky", ovr_err, 1);

    // Randomised accesses against the model
    for (int i = 0; i < 16; i++) begin
      a  = AW'($urandom);
      st = sts[$urandom_range(0, 5)];
      set_addr(a);
      chk("rnd.errclr", {bus_err, ovr_err}, {m_berr, m_oerr});
      set_status(st);
      if (st[1] && !st[2]) serve("rnd_rd", 0, m_addr, 0, $urandom_range(0, 4), DW'($urandom));
      else chk("rnd.noreq", bus.bus_req, 0);
      for (int j = 0; j < 2; j++) begin
        w = DW'($urandom);
        send_data(w);
        if (st[2])      serve("rnd_wr", 1, m_addr, w, $urandom_range(0, 4), DW'($urandom));
        else if (st[0]) serve("rnd_pf", 0, m_addr, 0, $urandom_range(0, 4), DW'($urandom));
        else            chk("rnd.nopf", bus.bus_req, 0);
      end
    end

    // Reset in the middle of a write
    set_addr(20'h00ABC);
    set_status(4'b0100);
    send_data(16'hAAAA);
    chk("mid.req_before", bus.bus_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid.req", bus.bus_req, 0);
    chk("mid.we", bus.bus_we, 0);
    chk("mid.addr", bus.bus_addr, 0);
    chk("mid.wdata", bus.bus_wdata, 0);
    chk("mid.rdata", rdata, 0);
    chk("mid.flags", {busy, bus_err, ovr_err}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.bus_req !== 1'b0) n++;
    end
    chk("mid.noreplay", n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
